// File: rtl/dmem_responder.sv
// Data-memory responder for the MCU load/store port.
// One request at a time over valid/ready, a programmable number of wait
// states, byte-lane stores, and sticky pass/fail flags driven by stores to
// the self-check addresses, plus a saturating committed-store counter.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 1,
  parameter int PASS_ADDR   = 100,
  parameter int PASS_DATA   = 7,
  parameter int ALLOW_ADDR  = 96
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        pass,
  output logic        fail,
  output logic [15:0] wr_count
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t       state;
  logic [3:0]   waitCnt;
  logic         writeReg;
  logic [31:0]  addrReg;
  logic [31:0]  wdataReg;
  logic [3:0]   beReg;
  logic [31:0]  mem [DEPTH_WORDS];

  logic         accept;
  logic         doAccess;
  logic         accWrite;
  logic [31:0]  accAddr;
  logic [31:0]  accWdata;
  logic [3:0]   accBe;
  logic         accErr;
  logic [AW-1:0] accIdx;
  logic         commitStore;

  // Misaligned or beyond the end of the memory.
  function automatic logic addrErr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS));
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;

  // Pick the request being accessed: live inputs when accessing on the
  // acceptance edge (no wait states), otherwise the captured copy.
  always_comb begin
    accWrite = writeReg;
    accAddr  = addrReg;
    accWdata = wdataReg;
    accBe    = beReg;
    if (state == IDLE) begin
      accWrite = req_write;
      accAddr  = req_addr;
      accWdata = req_wdata;
      accBe    = req_be;
    end
    accErr      = addrErr(accAddr);
    accIdx      = accAddr[AW+1:2];
    doAccess    = (WAIT_STATES == 0) ? accept : ((state == WAIT) && (waitCnt == 4'd0));
    commitStore = doAccess & accWrite & ~accErr;
  end

  // Capture request fields on acceptance (data path, no reset).
  always_ff @(posedge clk) begin
    if (accept) begin
      writeReg <= req_write;
      addrReg  <= req_addr;
      wdataReg <= req_wdata;
      beReg    <= req_be;
    end
  end

  // Byte-lane store into the memory array.
  always_ff @(posedge clk) begin
    if (commitStore) begin
      for (int i = 0; i < 4; i++) begin
        if (accBe[i]) mem[accIdx][8*i +: 8] <= accWdata[8*i +: 8];
      end
    end
  end

  // Control FSM, response registers, flags and store counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      waitCnt   <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      wr_count  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && (WAIT_STATES > 0)) begin
            state   <= WAIT;
            waitCnt <= WAIT_INIT;
          end
        end
        WAIT: begin
          waitCnt <= waitCnt - 4'd1;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (doAccess) begin
        state     <= RESP;
        rsp_valid <= 1'b1;
        rsp_err   <= accErr;
        rsp_rdata <= (accWrite || accErr) ? 32'd0 : mem[accIdx];
        if (commitStore) begin
          wr_count <= satInc(wr_count);
          if ((accAddr == 32'(PASS_ADDR)) && (accWdata == 32'(PASS_DATA)))
            pass <= 1'b1;
          else if (accAddr != 32'(ALLOW_ADDR))
            fail <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the MCU core's load/store port: the memory-side end of the bus on which the core issues `MemWrite`/`DataAdr`/`WriteData` traffic. It accepts one request at a time through a valid/ready handshake, inserts a programmable number of wait states, and commits writes with byte-lane enables. It returns read data through a second valid/ready handshake. In hardware it also implements the team's store-based self-check convention as sticky PASS/FAIL flags and a committed-write counter.

## Interface
- `DEPTH_WORDS`, 64: memory size in 32-bit words, power of two, at least 4.
- `WAIT_STATES`, 1: extra cycles between request acceptance and access, range 0–15.
- `PASS_ADDR`, 100: byte address of the success store.
- `PASS_DATA`, 7: data value that signals success.
- `ALLOW_ADDR`, 96: byte address where stores are legal without affecting the flags.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request. High only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `req_be`  in  4  byte enables; bit i covers bits [8i+7:8i].
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_rdata`  out  32  load data. It is 0 for stores and for errors.
- `rsp_err`  out  1  the request was misaligned or out of range.
- `pass`  out  1  sticky success flag.
- `fail`  out  1  sticky failure flag.
- `wr_count`  out  16  number of committed stores; saturates at 0xFFFF.

## Operation
- States and transitions:
  - IDLE → WAIT on an accepted request when `WAIT_STATES` > 0. Acceptance means `req_valid & req_ready` at a rising edge.
  - IDLE → RESP on an accepted request when `WAIT_STATES` = 0. The access is performed on that same edge.
  - WAIT → RESP on the edge where the wait counter is 0. The access is performed on that edge.
  - RESP → IDLE on `rsp_ready`.
- Request capture:
  - The request fields are registered on acceptance.
  - Inputs are ignored outside IDLE.
  - The wait counter loads `WAIT_STATES`-1 on entry to WAIT and decrements every cycle in WAIT.
- Error check:
  - `rsp_err` = (`addr[1:0]` ≠ 0) OR (`addr[31:2]` ≥ `DEPTH_WORDS`).
  - An errored request has no memory effect, does not increment `wr_count`, and does not touch the flags.
- Store commit:
  - The word at index `addr[log2(DEPTH_WORDS)+1:2]` is updated only in the lanes whose `be` bit is 1.
  - `wr_count` increments on every committed store, including `be`=0.
- Load:
  - `rsp_rdata` is the full 32-bit word, regardless of `be`.
- Flags, evaluated on each committed store using the full `req_addr` and `req_wdata`, ignoring `be`:
  - addr = `PASS_ADDR` and data = `PASS_DATA` → set `pass`.
  - Otherwise, addr ≠ `ALLOW_ADDR` → set `fail`. This includes `PASS_ADDR` with the wrong data.
  - Otherwise, no change.
  - The two flags are independent; both can end up set.
- Reset:
  - Asynchronous assertion forces IDLE.
  - The following outputs go to 0: `rsp_valid`, `rsp_rdata`, `rsp_err`, `pass`, `fail`, `wr_count`.
  - `req_ready` goes to 1 once reset is released.
  - Reset mid-operation drops the pending request. A store already committed stays in memory.
  - Memory contents are not reset; reads of never-written words are unspecified.

## Timing
- Response latency:
  - Accept at edge E0; `rsp_valid` is first high after edge E0+`WAIT_STATES`.
  - With `WAIT_STATES`=0, `rsp_valid` is high in the cycle right after acceptance.
- Response hold:
  - `rsp_valid`, `rsp_rdata` and `rsp_err` stay stable until `rsp_ready` is sampled high.
- Throughput:
  - With `rsp_ready` tied high, RESP lasts 1 cycle.
  - The next acceptance is possible at E0+`WAIT_STATES`+2, so the peak rate is one request per `WAIT_STATES`+2 cycles.
- Side-effect timing:
  - Store data, `wr_count`, `pass` and `fail` become visible after the access edge, in the same cycle that `rsp_valid` rises.
- Back-to-back access:
  - A load to an address stored by the immediately preceding request returns the new data.
- Saturation:
  - `wr_count` at 0xFFFF stays at 0xFFFF.

## Test plan
- Core self-check sequence: store 0x0000000B to 96, then 7 to 100, all `be`=0xF → `pass`=1, `fail`=0, `wr_count`=2; `rsp_err`=0 on both.
- Bad store: store 7 to 104, then 5 to 100 → `fail`=1 after the first store; `pass` stays 0; `wr_count`=2.
- Byte lanes:
  - Store 0xAABBCCDD to 0, `be`=0xF.
  - Store 0x11223344 to 0, `be`=0b0101.
  - Load 0 → `rsp_rdata`=0xAA22CC44.
- Latency and backpressure, `WAIT_STATES`=3:
  - Load accepted at E0 → `rsp_valid` after E3.
  - Hold `rsp_ready`=0 for 4 cycles → response stable and `req_ready`=0 throughout.
- Errors: store to 0x102 (misaligned), then a load from `DEPTH_WORDS`*4 (out of range) → `rsp_err`=1, `rsp_rdata`=0 on both; no memory change, no flag change, `wr_count` unchanged.
- Reset mid-WAIT: assert `reset` during WAIT of a store → outputs go to 0 immediately; after release `req_ready`=1; the target word keeps its old value.
